// File: rtl/video_mode_pkg.sv
// Shared types for the video-mode sequencer: FSM state encoding and frame counter width.
package video_mode_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WAIT_FB,
    MUTE,
    APPLY,
    SETTLE
  } state_t;

endpackage

// File: rtl/vsync_edge_wdog.sv
// Frame-boundary detector: registered VSync leading-edge pulse plus a watchdog that
// substitutes a pseudo-boundary after 2^TIMEOUT_W enabled cycles without one.
module vsync_edge_wdog #(
  parameter int VS_POL    = 0,
  parameter int TIMEOUT_W = 22
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic i_vsync,
  input  logic i_wd_en,
  input  logic i_wd_clr,
  output logic o_ev,
  output logic o_vs_timeout
);

  // Reset the delayed sample to the active level so a release never fakes a leading edge.
  localparam logic LP_ACT = (VS_POL != 0);

  logic                 r_vs_d;
  logic                 r_fb;
  logic                 r_pfb;
  logic                 r_vs_timeout;
  logic [TIMEOUT_W-1:0] r_wd;
  logic                 w_lead;
  logic                 w_term;

  assign w_lead = (VS_POL != 0) ? (i_vsync & ~r_vs_d) : (~i_vsync & r_vs_d);
  assign w_term = i_wd_en & ~i_wd_clr & ~r_fb & (&r_wd);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_vs_d       <= LP_ACT;
      r_fb         <= 1'b0;
      r_pfb        <= 1'b0;
      r_vs_timeout <= 1'b0;
      r_wd         <= '0;
    end else begin
      r_vs_d <= i_vsync;
      r_fb   <= w_lead;
      r_pfb  <= w_term;
      if (r_fb || i_wd_clr || w_term) begin
        r_wd <= '0;
      end else if (i_wd_en) begin
        r_wd <= r_wd + TIMEOUT_W'(1);
      end
      if (w_term) begin
        r_vs_timeout <= 1'b1;
      end else if (r_fb) begin
        r_vs_timeout <= 1'b0;
      end
    end
  end

  assign o_ev         = r_fb | r_pfb;
  assign o_vs_timeout = r_vs_timeout;

endmodule

// File: rtl/video_mode_ctrl.sv
// Applies video-mode requests at frame boundaries; sync-topology changes are wrapped in
// MUTE_FRAMES + SETTLE_FRAMES of forced black. Scanline-only changes land 1 cycle after the boundary.
module video_mode_ctrl
  import video_mode_pkg::*;
#(
  parameter int MUTE_FRAMES   = 2,
  parameter int SETTLE_FRAMES = 3,
  parameter int VS_POL        = 0,
  parameter int TIMEOUT_W     = 22
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       vsync_in,
  input  logic       sd_disable_req,
  input  logic       ypbpr_req,
  input  logic [1:0] scanlines_req,
  output logic       scandoubler_disable,
  output logic       ypbpr,
  output logic [1:0] scanlines,
  output logic       blank,
  output logic       busy,
  output logic       vs_timeout
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (MUTE_FRAMES < 1 || MUTE_FRAMES > CNT_MAX) begin : g_bad_mute
    $error("video_mode_ctrl: MUTE_FRAMES must be 1..15");
  end
  if (SETTLE_FRAMES < 1 || SETTLE_FRAMES > CNT_MAX) begin : g_bad_settle
    $error("video_mode_ctrl: SETTLE_FRAMES must be 1..15");
  end

  localparam logic [CNT_W-1:0] LP_MUTE   = CNT_W'(MUTE_FRAMES);
  localparam logic [CNT_W-1:0] LP_SETTLE = CNT_W'(SETTLE_FRAMES);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_topo;
  logic             w_topo_nxt;
  logic             r_sd;
  logic             w_sd_nxt;
  logic             r_yp;
  logic             w_yp_nxt;
  logic [1:0]       r_sl;
  logic [1:0]       w_sl_nxt;
  logic             r_blank;
  logic             r_busy;
  logic             w_ev;
  logic             w_wd_en;
  logic             w_wd_clr;

  assign w_wd_en  = (r_state == WAIT_FB) || (r_state == MUTE) || (r_state == SETTLE);
  assign w_wd_clr = (w_state_nxt != r_state);

  vsync_edge_wdog #(
    .VS_POL    (VS_POL),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_edge_wdog (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .i_vsync      (vsync_in),
    .i_wd_en      (w_wd_en),
    .i_wd_clr     (w_wd_clr),
    .o_ev         (w_ev),
    .o_vs_timeout (vs_timeout)
  );

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_topo_nxt  = r_topo;
    w_sd_nxt    = r_sd;
    w_yp_nxt    = r_yp;
    w_sl_nxt    = r_sl;
    case (r_state)
      INIT, APPLY: begin
        w_sd_nxt    = sd_disable_req;
        w_yp_nxt    = ypbpr_req;
        w_sl_nxt    = scanlines_req;
        w_cnt_nxt   = '0;
        w_state_nxt = SETTLE;
      end
      IDLE: begin
        // A boundary seen here is ignored; the change waits for the following one.
        if ((sd_disable_req != r_sd) || (ypbpr_req != r_yp)) begin
          w_topo_nxt  = 1'b1;
          w_state_nxt = WAIT_FB;
        end else if (scanlines_req != r_sl) begin
          w_topo_nxt  = 1'b0;
          w_state_nxt = WAIT_FB;
        end
      end
      WAIT_FB: begin
        if (w_ev) begin
          if (r_topo) begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = MUTE;
          end else begin
            w_sl_nxt    = scanlines_req;
            w_state_nxt = IDLE;
          end
        end
      end
      MUTE: begin
        if (w_ev) begin
          if (r_cnt == LP_MUTE) begin
            w_state_nxt = APPLY;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      SETTLE: begin
        if (w_ev) begin
          if (w_cnt_inc == LP_SETTLE) begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: begin
        w_state_nxt = INIT;
      end
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_topo  <= 1'b0;
      r_sd    <= 1'b0;
      r_yp    <= 1'b0;
      r_sl    <= 2'd0;
      r_blank <= 1'b1;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_topo  <= w_topo_nxt;
      r_sd    <= w_sd_nxt;
      r_yp    <= w_yp_nxt;
      r_sl    <= w_sl_nxt;
      r_blank <= (w_state_nxt == INIT) || (w_state_nxt == MUTE) ||
                 (w_state_nxt == APPLY) || (w_state_nxt == SETTLE);
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  assign scandoubler_disable = r_sd;
  assign ypbpr               = r_yp;
  assign scanlines           = r_sl;
  assign blank               = r_blank;
  assign busy                = r_busy;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed bench: u_dut uses default parameters with a 1000-cycle VSync; u_wd (TIMEOUT_W=8) sees a dead VSync.
module tb_video_mode_ctrl;

  localparam int PER = 1000;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       vsync_in;
  logic       sd_req;
  logic       yp_req;
  logic [1:0] sl_req;
  logic       sd_out;
  logic       yp_out;
  logic [1:0] sl_out;
  logic       blank;
  logic       busy;
  logic       vs_to;

  logic       wd_rst;
  logic       wd_vsync;
  logic       wd_yp_req;
  logic       wd_sd;
  logic       wd_yp;
  logic [1:0] wd_sl;
  logic       wd_blank;
  logic       wd_busy;
  logic       wd_to;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_sys = ~clk_sys;

  video_mode_ctrl u_dut (
    .clk_sys             (clk_sys),
    .reset               (reset),
    .vsync_in            (vsync_in),
    .sd_disable_req      (sd_req),
    .ypbpr_req           (yp_req),
    .scanlines_req       (sl_req),
    .scandoubler_disable (sd_out),
    .ypbpr               (yp_out),
    .scanlines           (sl_out),
    .blank               (blank),
    .busy                (busy),
    .vs_timeout          (vs_to)
  );

  video_mode_ctrl #(.TIMEOUT_W(8)) u_wd (
    .clk_sys             (clk_sys),
    .reset               (wd_rst),
    .vsync_in            (wd_vsync),
    .sd_disable_req      (1'b0),
    .ypbpr_req           (wd_yp_req),
    .scanlines_req       (2'd0),
    .scandoubler_disable (wd_sd),
    .ypbpr               (wd_yp),
    .scanlines           (wd_sl),
    .blank               (wd_blank),
    .busy                (wd_busy),
    .vs_timeout          (wd_to)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // {scandoubler_disable, ypbpr, scanlines[1:0], blank, busy}
  function automatic logic [31:0] outs();
    return {26'd0, sd_out, yp_out, sl_out, blank, busy};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Leading edge at the current negedge; returns in the cycle where fb is high.
  task automatic vs_lead();
    vsync_in = 1'b0;
    tick(1);
  endtask

  // Finish the frame; k = cycles already spent since the leading edge (1..4).
  task automatic vs_tail(input int k);
    tick(4 - k);
    vsync_in = 1'b1;
    tick(PER - 4);
  endtask

  task automatic vs_frame();
    vs_lead();
    vs_tail(1);
  endtask

  initial begin
    reset     = 1'b1;
    vsync_in  = 1'b1;
    sd_req    = 1'b1;
    yp_req    = 1'b0;
    sl_req    = 2'd2;
    wd_rst    = 1'b1;
    wd_vsync  = 1'b1;
    wd_yp_req = 1'b0;

    // Reset, INIT load, three settle frames
    tick(3);
    check("rst_outs", outs(), 32'b00_00_1_1);
    check("rst_vs_to", {31'd0, vs_to}, 32'd0);
    reset = 1'b0;
    tick(1);
    check("init_load", outs(), 32'b10_10_1_1);
    tick(5);
    vs_frame();
    vs_frame();
    vs_lead();
    check("settle_fb3", outs(), 32'b10_10_1_1);
    tick(1);
    check("settle_done", outs(), 32'b10_10_0_0);
    vs_tail(2);

    // Scanlines-only change: 1 cycle after fb, no blanking
    sl_req = 2'd3;
    tick(1);
    check("sl_wait", outs(), 32'b10_10_0_1);
    tick(100);
    vs_lead();
    check("sl_at_fb", outs(), 32'b10_10_0_1);
    tick(1);
    check("sl_applied", outs(), 32'b10_11_0_0);
    vs_tail(2);

    // Topology change: 2 mute frames, apply, 3 settle frames
    sd_req = 1'b0;
    tick(1);
    check("topo_wait", outs(), 32'b10_11_0_1);
    tick(100);
    vs_lead();
    check("topo_at_fb", outs(), 32'b10_11_0_1);
    tick(1);
    check("mute_start", outs(), 32'b10_11_1_1);
    vs_tail(2);
    vs_frame();
    vs_lead();
    tick(1);
    check("apply_state", outs(), 32'b10_11_1_1);
    tick(1);
    check("apply_load", outs(), 32'b00_11_1_1);
    vs_tail(3);
    vs_frame();
    vs_frame();
    vs_lead();
    check("settle_last", outs(), 32'b00_11_1_1);
    tick(1);
    check("topo_done", outs(), 32'b00_11_0_0);
    vs_tail(2);

    // Request toggles back during MUTE, plus a scanlines change picked up at APPLY
    sd_req = 1'b1;
    tick(50);
    vs_lead();
    tick(1);
    check("tog_mute", outs(), 32'b00_11_1_1);
    vs_tail(2);
    sd_req = 1'b0;
    sl_req = 2'd1;
    vs_frame();
    vs_lead();
    tick(1);
    check("tog_apply_st", outs(), 32'b00_11_1_1);
    tick(1);
    check("tog_apply", outs(), 32'b00_01_1_1);
    vs_tail(3);
    vs_frame();
    vs_frame();
    vs_lead();
    tick(1);
    check("tog_done", outs(), 32'b00_01_0_0);
    vs_tail(2);
    check("tog_idle_hold", outs(), 32'b00_01_0_0);

    // Request arriving in the fb cycle is not consumed by that fb
    vs_lead();
    yp_req = 1'b1;
    tick(1);
    check("late_req_wait", outs(), 32'b00_01_0_1);
    vs_tail(2);
    check("late_req_noblank", outs(), 32'b00_01_0_1);
    vs_lead();
    tick(1);
    check("late_req_mute", outs(), 32'b00_01_1_1);
    vs_tail(2);
    tick(200);

    // Async reset in MUTE, then INIT and SETTLE
    reset = 1'b1;
    #1;
    check("async_rst", outs(), 32'b00_00_1_1);
    tick(3);
    reset = 1'b0;
    tick(1);
    check("reinit_load", outs(), 32'b01_01_1_1);
    vs_frame();
    vs_frame();
    vs_lead();
    tick(1);
    check("reinit_done", outs(), 32'b01_01_0_0);
    vs_tail(2);
    check("main_vs_to", {31'd0, vs_to}, 32'd0);

    // Watchdog: dead VSync, 256-cycle pseudo-boundaries
    wd_rst = 1'b0;
    tick(256);
    check("wd_to_before", {31'd0, wd_to}, 32'd0);
    tick(1);
    check("wd_to_set", {31'd0, wd_to}, 32'd1);
    tick(512);
    check("wd_settle_blank", {30'd0, wd_blank, wd_busy}, 32'b11);
    tick(1);
    check("wd_idle", {30'd0, wd_blank, wd_busy}, 32'b00);
    wd_yp_req = 1'b1;
    tick(257);
    check("wd_wait_fb", {30'd0, wd_blank, wd_busy}, 32'b01);
    tick(1);
    check("wd_mute", {30'd0, wd_blank, wd_busy}, 32'b11);
    tick(513);
    check("wd_pre_apply", {31'd0, wd_yp}, 32'd0);
    tick(1);
    check("wd_apply", {26'd0, wd_sd, wd_yp, wd_sl, wd_blank, wd_busy}, 32'b01_00_1_1);
    tick(768);
    check("wd_settle_end", {30'd0, wd_blank, wd_busy}, 32'b11);
    tick(1);
    check("wd_done", {30'd0, wd_blank, wd_busy}, 32'b00);
    check("wd_to_sticky", {31'd0, wd_to}, 32'd1);
    wd_vsync = 1'b0;
    tick(1);
    check("wd_to_at_fb", {31'd0, wd_to}, 32'd1);
    tick(1);
    check("wd_to_clear", {31'd0, wd_to}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
